// File: rtl/fault_recovery_seq.sv
// Supervisory recovery sequencer beside the fault detection FSM: sequences contactor close-up,
// trips on faults, cools down, requests clear, and latches a lockout when retries are exhausted.
module fault_recovery_seq #(
    parameter int P_START   = 4,
    parameter int P_COOL    = 8,
    parameter int P_ACK_TO  = 6,
    parameter int MAX_RETRY = 2,
    parameter int P_RUN_OK  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] fsm_state,
    input  logic [2:0] active_fault_id,
    input  logic       clear_req,
    output logic       clear_warning,
    output logic       contactor_en,
    output logic       lockout,
    output logic [3:0] retry_cnt,
    output logic [2:0] last_fault_id,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_STARTUP = 3'd0,
        S_RUN     = 3'd1,
        S_TRIP    = 3'd2,
        S_COOL    = 3'd3,
        S_CLEAR   = 3'd4,
        S_LOCKOUT = 3'd5
    } seq_t;

    localparam logic [1:0]  F_NORMAL = 2'd0;
    localparam logic [1:0]  F_WARN   = 2'd1;
    localparam logic [1:0]  F_FAULT  = 2'd2;
    localparam logic [1:0]  F_SHUT   = 2'd3;
    localparam logic [15:0] T_START  = 16'(P_START - 1);
    localparam logic [15:0] T_COOL   = 16'(P_COOL - 1);
    localparam logic [15:0] T_ACK    = 16'(P_ACK_TO - 1);
    localparam logic [15:0] T_RUN_OK = 16'(P_RUN_OK - 1);
    localparam logic [3:0]  R_MAX    = 4'(MAX_RETRY);

    seq_t        state, nxt;
    logic [15:0] timer, warn_cnt, warn_nxt, ok_cnt, ok_nxt;
    logic        counted, capture, warn_pulse, retry_clr;
    logic        shut, fault_on;

    assign shut      = (fsm_state == F_SHUT);
    assign fault_on  = (active_fault_id != 3'd0);
    assign seq_state = state;

    always_comb begin
        nxt        = state;
        counted    = 1'b0;
        capture    = 1'b0;
        warn_pulse = 1'b0;
        retry_clr  = 1'b0;
        warn_nxt   = 16'd0;
        ok_nxt     = 16'd0;
        case (state)
            S_STARTUP: begin
                if (shut)                         nxt = S_LOCKOUT;
                else if (fsm_state != F_NORMAL)   counted = 1'b1;
                else if (timer == T_START)        nxt = S_RUN;
            end
            S_RUN: begin
                if (shut)                         nxt = S_LOCKOUT;
                else if (fsm_state == F_FAULT)    counted = 1'b1;
                else begin
                    // clean-warning and healthy-run counters only advance on consecutive qualifying cycles
                    if (fsm_state == F_WARN && !fault_on) begin
                        if (warn_cnt == T_COOL) warn_pulse = 1'b1;
                        else                    warn_nxt   = warn_cnt + 16'd1;
                    end
                    if (fsm_state == F_NORMAL) begin
                        if (ok_cnt == T_RUN_OK) begin
                            retry_clr = 1'b1;
                            ok_nxt    = ok_cnt;
                        end else begin
                            ok_nxt    = ok_cnt + 16'd1;
                        end
                    end
                end
            end
            S_TRIP: begin
                if (shut)                         nxt = S_LOCKOUT;
                else if (!fault_on)               nxt = S_COOL;
            end
            S_COOL: begin
                if (shut)                         nxt = S_LOCKOUT;
                else if (fault_on) begin
                    nxt     = S_TRIP;
                    capture = 1'b1;
                end
                else if (timer == T_COOL)         nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (shut)                         nxt = S_LOCKOUT;
                else if (fault_on) begin
                    nxt     = S_TRIP;
                    capture = 1'b1;
                end
                else if (fsm_state == F_NORMAL)   nxt = S_STARTUP;
                else if (timer == T_ACK)          nxt = S_LOCKOUT;
            end
            S_LOCKOUT: begin
                if (clear_req && !shut) begin
                    nxt       = S_COOL;
                    retry_clr = 1'b1;
                end
            end
            default: nxt = S_STARTUP;
        endcase
        // an exhausted retry budget diverts a counted trip straight to lockout
        if (counted) begin
            capture = 1'b1;
            nxt     = (retry_cnt == R_MAX) ? S_LOCKOUT : S_TRIP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_STARTUP;
            timer         <= 16'd0;
            warn_cnt      <= 16'd0;
            ok_cnt        <= 16'd0;
            retry_cnt     <= 4'd0;
            last_fault_id <= 3'd0;
            clear_warning <= 1'b0;
            contactor_en  <= 1'b0;
            lockout       <= 1'b0;
        end else begin
            state    <= nxt;
            warn_cnt <= warn_nxt;
            ok_cnt   <= ok_nxt;
            if (nxt != state)             timer <= 16'd0;
            else if (timer != 16'hffff)   timer <= timer + 16'd1;
            if (retry_clr)
                retry_cnt <= 4'd0;
            else if (counted && retry_cnt != R_MAX && retry_cnt != 4'hf)
                retry_cnt <= retry_cnt + 4'd1;
            if (capture) last_fault_id <= active_fault_id;
            // outputs decoded from the next state so they line up with the state register
            clear_warning <= (nxt == S_CLEAR) || warn_pulse;
            contactor_en  <= (nxt == S_RUN);
            lockout       <= (nxt == S_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_fault_recovery_seq.sv
// Directed bench for fault_recovery_seq: a vector table for the main recovery path plus
// hand sequences for warning clear, run-ok retry reset, COOL re-trip and async reset.
module tb_fault_recovery_seq;

    localparam logic [1:0] NRM = 2'd0, WRN = 2'd1, FLT = 2'd2, SHD = 2'd3;
    localparam logic [2:0] ST = 3'd0, RN = 3'd1, TR = 3'd2, CL = 3'd3, CR = 3'd4, LO = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] fsm_state;
    logic [2:0] active_fault_id;
    logic       clear_req;
    logic       clear_warning, contactor_en, lockout;
    logic [3:0] retry_cnt;
    logic [2:0] last_fault_id, seq_state;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic [1:0] fs;
        logic [2:0] fid;
        logic       cr;
        int         n;
        logic [2:0] st;
        logic       ce, cw, lo;
        logic [3:0] rc;
        logic [2:0] lf;
    } vec_t;

    vec_t tbl[25];

    fault_recovery_seq dut (
        .clk(clk), .rst_n(rst_n), .fsm_state(fsm_state), .active_fault_id(active_fault_id),
        .clear_req(clear_req), .clear_warning(clear_warning), .contactor_en(contactor_en),
        .lockout(lockout), .retry_cnt(retry_cnt), .last_fault_id(last_fault_id),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] fs, input logic [2:0] fid, input logic cr);
        fsm_state       = fs;
        active_fault_id = fid;
        clear_req       = cr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic ce, input logic cw,
                       input logic lo, input logic [3:0] rc, input logic [2:0] lf);
        total++;
        if (seq_state === st && contactor_en === ce && clear_warning === cw &&
            lockout === lo && retry_cnt === rc && last_fault_id === lf)
            passed++;
        else
            $display("FAIL %s: got st=%0d ce=%b cw=%b lo=%b rc=%0d lf=%0d, want st=%0d ce=%b cw=%b lo=%b rc=%0d lf=%0d",
                     nm, seq_state, contactor_en, clear_warning, lockout, retry_cnt, last_fault_id,
                     st, ce, cw, lo, rc, lf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(NRM, 3'd0, 1'b0);
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        //            fs   fid  cr  n   st  ce cw lo rc  lf
        tbl[0]  = '{NRM, 3'd0, 0, 3, ST, 0, 0, 0, 4'd0, 3'd0};
        tbl[1]  = '{NRM, 3'd0, 0, 1, RN, 1, 0, 0, 4'd0, 3'd0};
        tbl[2]  = '{FLT, 3'd3, 0, 1, TR, 0, 0, 0, 4'd1, 3'd3};
        tbl[3]  = '{FLT, 3'd3, 0, 2, TR, 0, 0, 0, 4'd1, 3'd3};
        tbl[4]  = '{FLT, 3'd0, 0, 1, CL, 0, 0, 0, 4'd1, 3'd3};
        tbl[5]  = '{FLT, 3'd0, 0, 7, CL, 0, 0, 0, 4'd1, 3'd3};
        tbl[6]  = '{FLT, 3'd0, 0, 1, CR, 0, 1, 0, 4'd1, 3'd3};
        tbl[7]  = '{NRM, 3'd0, 0, 1, ST, 0, 0, 0, 4'd1, 3'd3};
        tbl[8]  = '{NRM, 3'd0, 0, 3, ST, 0, 0, 0, 4'd1, 3'd3};
        tbl[9]  = '{NRM, 3'd0, 0, 1, RN, 1, 0, 0, 4'd1, 3'd3};
        tbl[10] = '{FLT, 3'd5, 0, 1, TR, 0, 0, 0, 4'd2, 3'd5};
        tbl[11] = '{FLT, 3'd0, 0, 8, CL, 0, 0, 0, 4'd2, 3'd5};
        tbl[12] = '{FLT, 3'd0, 0, 1, CR, 0, 1, 0, 4'd2, 3'd5};
        tbl[13] = '{NRM, 3'd0, 0, 4, ST, 0, 0, 0, 4'd2, 3'd5};
        tbl[14] = '{NRM, 3'd0, 0, 1, RN, 1, 0, 0, 4'd2, 3'd5};
        tbl[15] = '{FLT, 3'd6, 0, 1, LO, 0, 0, 1, 4'd2, 3'd6};
        tbl[16] = '{FLT, 3'd0, 0, 3, LO, 0, 0, 1, 4'd2, 3'd6};
        tbl[17] = '{FLT, 3'd0, 1, 1, CL, 0, 0, 0, 4'd0, 3'd6};
        tbl[18] = '{FLT, 3'd0, 0, 7, CL, 0, 0, 0, 4'd0, 3'd6};
        tbl[19] = '{FLT, 3'd0, 0, 1, CR, 0, 1, 0, 4'd0, 3'd6};
        tbl[20] = '{WRN, 3'd0, 0, 5, CR, 0, 1, 0, 4'd0, 3'd6};
        tbl[21] = '{WRN, 3'd0, 0, 1, LO, 0, 0, 1, 4'd0, 3'd6};
        tbl[22] = '{SHD, 3'd0, 1, 3, LO, 0, 0, 1, 4'd0, 3'd6};
        tbl[23] = '{NRM, 3'd0, 1, 1, CL, 0, 0, 0, 4'd0, 3'd6};
        tbl[24] = '{SHD, 3'd0, 0, 1, LO, 0, 0, 1, 4'd0, 3'd6};

        rst_n = 1'b0;
        drive(NRM, 3'd0, 1'b0);
        tick(2);
        chk("reset_state", ST, 0, 0, 0, 4'd0, 3'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].fs, tbl[i].fid, tbl[i].cr);
            tick(tbl[i].n);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].ce, tbl[i].cw, tbl[i].lo, tbl[i].rc, tbl[i].lf);
        end

        // warning clean-count with a restart at cycle 5, then run-ok retry clear
        do_reset();
        tick(4);
        chk("warn_run", RN, 1, 0, 0, 4'd0, 3'd0);
        drive(WRN, 3'd0, 1'b0); tick(4);
        chk("warn_4", RN, 1, 0, 0, 4'd0, 3'd0);
        drive(WRN, 3'd2, 1'b0); tick(1);
        drive(WRN, 3'd0, 1'b0); tick(4);
        chk("warn_restart4", RN, 1, 0, 0, 4'd0, 3'd0);
        tick(3);
        chk("warn_restart7", RN, 1, 0, 0, 4'd0, 3'd0);
        tick(1);
        chk("warn_pulse", RN, 1, 1, 0, 4'd0, 3'd0);
        tick(1);
        chk("warn_pulse_end", RN, 1, 0, 0, 4'd0, 3'd0);
        drive(FLT, 3'd7, 1'b0); tick(1);
        chk("trip7", TR, 0, 0, 0, 4'd1, 3'd7);
        drive(FLT, 3'd0, 1'b0); tick(8);
        chk("cool7", CL, 0, 0, 0, 4'd1, 3'd7);
        tick(1);
        chk("clear7", CR, 0, 1, 0, 4'd1, 3'd7);
        drive(NRM, 3'd0, 1'b0); tick(5);
        chk("rerun", RN, 1, 0, 0, 4'd1, 3'd7);
        tick(49);
        chk("run_ok_49", RN, 1, 0, 0, 4'd1, 3'd7);
        tick(1);
        chk("run_ok_50", RN, 1, 0, 0, 4'd0, 3'd7);

        // fault reappears in COOL (uncounted), then async reset mid-COOL
        drive(FLT, 3'd1, 1'b0); tick(1);
        chk("trip1", TR, 0, 0, 0, 4'd1, 3'd1);
        drive(FLT, 3'd0, 1'b0); tick(4);
        chk("cool_c4", CL, 0, 0, 0, 4'd1, 3'd1);
        drive(FLT, 3'd4, 1'b0); tick(1);
        chk("cool_retrip", TR, 0, 0, 0, 4'd1, 3'd4);
        drive(FLT, 3'd0, 1'b0); tick(3);
        chk("cool_again", CL, 0, 0, 0, 4'd1, 3'd4);
        rst_n = 1'b0; #1;
        chk("async_reset", ST, 0, 0, 0, 4'd0, 3'd0);
        tick(1);
        rst_n = 1'b1;

        // SHUTDOWN out of STARTUP and RUN, clear_req ignored while shut
        drive(SHD, 3'd0, 1'b0); tick(1);
        chk("shut_startup", LO, 0, 0, 1, 4'd0, 3'd0);
        drive(SHD, 3'd0, 1'b1); tick(2);
        chk("shut_clrreq", LO, 0, 0, 1, 4'd0, 3'd0);
        do_reset();
        tick(4);
        drive(SHD, 3'd0, 1'b0); tick(1);
        chk("shut_run", LO, 0, 0, 1, 4'd0, 3'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
